// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU/MDU unit.
//   - ALU_CTRL_W   : width of the op-select field
//   - alu_base_e   : 4-bit codes of the ten single-cycle base ops
//   - alu_ctrl_e   : full 5-bit op codes (base ops with bit4=0, M ops 10xxx)
//   - fsm_state_e  : sequencing states of alu_mdu_seq
//   - is_mdu_op()  : true for a legal M-extension code
//   - is_div_op()  : true for DIV/DIVU/REM/REMU
package alu_pkg;

   localparam int ALU_CTRL_W = 5;

   // Numerically identical to the original single-cycle ALU encoding.
   typedef enum logic [3:0] {
      BASE_ADD  = 4'b0000,
      BASE_SUB  = 4'b0001,
      BASE_AND  = 4'b0010,
      BASE_OR   = 4'b0011,
      BASE_XOR  = 4'b0100,
      BASE_SLT  = 4'b0101,
      BASE_SLTU = 4'b0110,
      BASE_SLL  = 4'b0111,
      BASE_SRL  = 4'b1000,
      BASE_SRA  = 4'b1001
   } alu_base_e;

   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_ADD    = 5'b00000,
      ALU_SUB    = 5'b00001,
      ALU_AND    = 5'b00010,
      ALU_OR     = 5'b00011,
      ALU_XOR    = 5'b00100,
      ALU_SLT    = 5'b00101,
      ALU_SLTU   = 5'b00110,
      ALU_SLL    = 5'b00111,
      ALU_SRL    = 5'b01000,
      ALU_SRA    = 5'b01001,
      ALU_MUL    = 5'b10000,
      ALU_MULH   = 5'b10001,
      ALU_MULHSU = 5'b10010,
      ALU_MULHU  = 5'b10011,
      ALU_DIV    = 5'b10100,
      ALU_DIVU   = 5'b10101,
      ALU_REM    = 5'b10110,
      ALU_REMU   = 5'b10111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } fsm_state_e;

   function automatic logic is_mdu_op(input logic [ALU_CTRL_W-1:0] ctrl);
      return ctrl[4] && !ctrl[3];
   endfunction

   function automatic logic is_div_op(input logic [ALU_CTRL_W-1:0] ctrl);
      return is_mdu_op(ctrl) && ctrl[2];
   endfunction

endpackage

// File: rtl/alu_base_comb.sv
// alu_base_comb: purely combinational XLEN-wide ALU for the ten base ops.
// Ports:
//   op     in  4     base op code (alu_base_e); unused codes give 0
//   a      in  XLEN  first operand
//   b      in  XLEN  second operand; shifts use b[SHW-1:0]
//   result out XLEN  op result (SLT/SLTU zero-extended 0/1)
module alu_base_comb
   import alu_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;
   assign shamt = b[SHW-1:0];

   // NOTE: every output of an always_comb gets a default first, so no path
   // through the case leaves it unassigned and no latch is inferred.
   always_comb begin
      result = '0;
      case (op)
         BASE_ADD:  result = a + b;
         BASE_SUB:  result = a - b;
         BASE_AND:  result = a & b;
         BASE_OR:   result = a | b;
         BASE_XOR:  result = a ^ b;
         BASE_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         BASE_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
         BASE_SLL:  result = a << shamt;
         BASE_SRL:  result = a >> shamt;
         BASE_SRA:  result = $signed(a) >>> shamt;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: registered ALU with iterative RV M-extension unit.
// Base ops (and illegal codes / M-op short-circuits) complete with latency 1;
// other M ops run one bit per cycle and complete with latency XLEN+1.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kills in-flight op or pending result (top priority)
//   in_valid / in_ready   op request handshake
//   alu_ctrl              5-bit op select (alu_ctrl_e)
//   operand_a, operand_b  XLEN-bit operands
//   out_valid / out_ready result handshake
//   result, zero          registered result and (result == 0)
module alu_mdu_seq
   import alu_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ALU_CTRL_W-1:0] alu_ctrl,
   input  logic [XLEN-1:0]       operand_a,
   input  logic [XLEN-1:0]       operand_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       result,
   output logic                  zero
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   // State and datapath registers.
   fsm_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ALU_CTRL_W-1:0] op_q, op_d;
   logic                  neg_q, neg_d;     // negate final result (sign fix)
   logic [XLEN-1:0]       opnd_q, opnd_d;   // multiplicand or divisor magnitude
   logic [2*XLEN-1:0]     acc_q, acc_d;     // {hi, lo}: product, or {remainder, quotient}
   logic [XLEN-1:0]       result_q, result_d;
   logic                  zero_q, zero_d;

   logic accept;

   // ------------------------------------------------------------------
   // Base ALU
   // ------------------------------------------------------------------
   logic [XLEN-1:0] base_result;

   alu_base_comb #(.XLEN(XLEN)) u_base (
      .op     (alu_ctrl[3:0]),
      .a      (operand_a),
      .b      (operand_b),
      .result (base_result)
   );

   // ------------------------------------------------------------------
   // Start-of-op decode: magnitudes, sign fix, 1-cycle results
   // ------------------------------------------------------------------
   logic              sign_a, sign_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              divisor_zero, div_overflow;
   logic              start_short;
   logic [XLEN-1:0]   short_result;
   logic [2*XLEN-1:0] start_acc;
   logic [XLEN-1:0]   start_opnd;
   logic              start_neg;

   always_comb begin
      sign_a = 1'b0;
      sign_b = 1'b0;
      case (alu_ctrl)
         ALU_MULH, ALU_DIV, ALU_REM: begin
            sign_a = operand_a[XLEN-1];
            sign_b = operand_b[XLEN-1];
         end
         ALU_MULHSU: sign_a = operand_a[XLEN-1];
         default: ;
      endcase

      // The most-negative value negates to itself, which is its correct
      // unsigned magnitude.
      mag_a = sign_a ? -operand_a : operand_a;
      mag_b = sign_b ? -operand_b : operand_b;

      divisor_zero = (operand_b == '0);
      div_overflow = (operand_a == MOST_NEG) && (operand_b == '1);

      start_short  = 1'b1;
      short_result = '0;
      if (!alu_ctrl[4]) begin
         short_result = base_result;
      end else if (!is_mdu_op(alu_ctrl)) begin
         short_result = '0;
      end else if (is_div_op(alu_ctrl) && divisor_zero) begin
         // bit1 distinguishes REM/REMU from DIV/DIVU
         short_result = alu_ctrl[1] ? operand_a : '1;
      end else if ((alu_ctrl == ALU_DIV || alu_ctrl == ALU_REM) && div_overflow) begin
         short_result = alu_ctrl[1] ? '0 : MOST_NEG;
      end else begin
         start_short = 1'b0;
      end

      if (is_div_op(alu_ctrl)) begin
         start_acc  = {{XLEN{1'b0}}, mag_a};
         start_opnd = mag_b;
         // Remainder takes the dividend's sign, quotient the XOR of signs.
         start_neg  = alu_ctrl[1] ? sign_a : (sign_a ^ sign_b);
      end else begin
         start_acc  = {{XLEN{1'b0}}, mag_b};
         start_opnd = mag_a;
         start_neg  = sign_a ^ sign_b;
      end
   end

   // ------------------------------------------------------------------
   // One iteration of the shift-add multiplier / restoring divider
   // ------------------------------------------------------------------
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift, div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] iter_next, prod_signed;
   logic [XLEN-1:0]   quo_signed, rem_signed;
   logic [XLEN-1:0]   final_result;

   always_comb begin
      // Multiply: add multiplicand into the high half when the current low
      // bit of the multiplier is set, then shift the whole product right.
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]}
               + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
      mul_next = {mul_sum, acc_q[XLEN-1:1]};

      // Divide: shift the next dividend bit into the partial remainder and
      // subtract the divisor if it fits; the borrow bit tells us it did not.
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = !div_diff[XLEN];
      div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                   acc_q[XLEN-2:0], div_ge};

      iter_next   = is_div_op(op_q) ? div_next : mul_next;
      prod_signed = neg_q ? -iter_next : iter_next;
      quo_signed  = neg_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
      rem_signed  = neg_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];

      case (op_q)
         ALU_MUL:                        final_result = prod_signed[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: final_result = prod_signed[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:              final_result = quo_signed;
         default:                        final_result = rem_signed;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM next-state and register updates
   // ------------------------------------------------------------------
   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;

   // in_ready already restricts accepts to IDLE or a draining DONE.
   assign accept = in_valid && in_ready && !flush;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      neg_d    = neg_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      result_d = result_q;
      zero_d   = zero_q;

      case (state_q)
         ST_BUSY: begin
            acc_d = iter_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               result_d = final_result;
               zero_d   = (final_result == '0);
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         op_d = alu_ctrl;
         if (start_short) begin
            result_d = short_result;
            zero_d   = (short_result == '0);
            state_d  = ST_DONE;
         end else begin
            cnt_d   = CNT_W'(XLEN);
            acc_d   = start_acc;
            opnd_d  = start_opnd;
            neg_d   = start_neg;
            state_d = ST_BUSY;
         end
      end

      // Flush wins over both accept and completion; the visible result is kept.
      if (flush) begin
         state_d  = ST_IDLE;
         result_d = result_q;
         zero_d   = zero_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Testbench for alu_mdu_seq: directed cases plus randomized ops checked
// against an arithmetic reference model; a second XLEN=16 instance covers
// the narrow build.
module tb_alu_mdu_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   // XLEN=32 instance
   logic        flush, in_valid, in_ready, out_valid, out_ready, zero;
   logic [4:0]  alu_ctrl;
   logic [31:0] operand_a, operand_b, result;

   alu_mdu_seq #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
      .operand_a(operand_a), .operand_b(operand_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero)
   );

   // XLEN=16 instance
   logic        f16, iv16, ir16, ov16, or16, z16;
   logic [4:0]  c16;
   logic [15:0] a16, b16, r16;

   alu_mdu_seq #(.XLEN(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .flush(f16),
      .in_valid(iv16), .in_ready(ir16), .alu_ctrl(c16),
      .operand_a(a16), .operand_b(b16),
      .out_valid(ov16), .out_ready(or16),
      .result(r16), .zero(z16)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: RV32IM semantics from plain arithmetic.
   function automatic logic [31:0] ref32(input logic [4:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [63:0] sa, sb, ub;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ub = {32'b0, b};
      case (c)
         ALU_ADD:    return a + b;
         ALU_SUB:    return a - b;
         ALU_AND:    return a & b;
         ALU_OR:     return a | b;
         ALU_XOR:    return a ^ b;
         ALU_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
         ALU_SLL:    return a << b[4:0];
         ALU_SRL:    return a >> b[4:0];
         ALU_SRA:    return $signed(a) >>> b[4:0];
         ALU_MUL:    return a * b;
         ALU_MULH:   begin p = sa * sb; return p[63:32]; end
         ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
         ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         ALU_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         ALU_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
         end
         ALU_REMU:   return (b == 0) ? a : a % b;
         default:    return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat32(input logic [4:0] c, input logic [31:0] a,
                                    input logic [31:0] b);
      logic is_m, is_d, ovf;
      is_m = (c >= 5'b10000) && (c <= 5'b10111);
      is_d = (c >= 5'b10100) && (c <= 5'b10111);
      ovf  = (c == ALU_DIV || c == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
      if (!is_m || (is_d && b == 0) || ovf) return 1;
      return 33;
   endfunction

   // Present one op, wait for accept and completion; lat counts cycles from
   // the accept cycle to the first out_valid cycle.
   task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      int n;
      int unsigned start;
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = c; operand_a = a; operand_b = b;
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      start = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      lat = int'(cyc - start);
   endtask

   task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      issue(c, a, b, lat);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " result"}, 64'(result), 64'(exp));
      check({tag, " zero"}, 64'(zero), 64'(exp == 32'd0));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run16(input string tag, input logic [4:0] c, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp, input int exp_lat);
      int n;
      int unsigned start;
      @(negedge clk);
      iv16 = 1'b1; c16 = c; a16 = a; b16 = b;
      start = cyc;
      @(negedge clk);
      iv16 = 1'b0;
      n = 0;
      while (!ov16 && n < 100) begin @(negedge clk); n++; end
      check({tag, " latency"}, 64'(cyc - start), 64'(exp_lat));
      check({tag, " result"}, 64'(r16), 64'(exp));
      or16 = 1'b1;
      @(negedge clk);
      or16 = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  codes [18];
      logic [4:0]  c;
      logic [31:0] a, b, prev;
      int lat, cnt;

      codes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
                ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL, ALU_MULH, ALU_MULHSU,
                ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

      flush = 0; in_valid = 0; out_ready = 0; alu_ctrl = 0; operand_a = 0; operand_b = 0;
      f16 = 0; iv16 = 0; or16 = 0; c16 = 0; a16 = 0; b16 = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset result", 64'(result), 64'd0);
      check("reset zero", 64'(zero), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;

      // ADD then SUB back-to-back with no bubble
      issue(ALU_ADD, 32'd15, 32'd10, lat);
      check("add latency", 64'(lat), 64'd1);
      check("add result", 64'(result), 64'd25);
      check("add zero", 64'(zero), 64'd0);
      out_ready = 1'b1; in_valid = 1'b1; alu_ctrl = ALU_SUB; operand_a = 32'd5; operand_b = 32'd5;
      #1;
      check("b2b in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b out_valid", 64'(out_valid), 64'd1);
      check("sub result", 64'(result), 64'd0);
      check("sub zero", 64'(zero), 64'd1);
      @(negedge clk);
      out_ready = 1'b0;

      // Multiply
      run_op("mul", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
      run_op("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);

      // Divide
      run_op("div", ALU_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
      run_op("rem", ALU_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
      run_op("divu", ALU_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);

      // Short-circuit corners
      run_op("div by 0", ALU_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("remu by 0", ALU_REMU, 32'd7, 32'd0, 32'd7, 1);
      run_op("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      run_op("illegal", 5'b11111, 32'd3, 32'd4, 32'd0, 1);

      // Backpressure: result held while out_ready stays low
      issue(ALU_DIV, 32'd100, 32'd7, lat);
      check("bp latency", 64'(lat), 64'd33);
      for (int i = 0; i < 5; i++) begin
         check("bp result", 64'(result), 64'd14);
         check("bp in_ready", 64'(in_ready), 64'd0);
         check("bp out_valid", 64'(out_valid), 64'd1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Flush during BUSY
      prev = result;
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = ALU_MUL; operand_a = 32'd9; operand_b = 32'd9;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("flush no out_valid", 64'(cnt), 64'd0);
      check("flush result held", 64'(result), 64'(prev));
      check("flush in_ready", 64'(in_ready), 64'd1);
      run_op("post-flush add", ALU_ADD, 32'd15, 32'd10, 32'd25, 1);

      // Reset mid-MUL
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = ALU_MUL; operand_a = 32'd1234; operand_b = 32'd77;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst out_valid", 64'(out_valid), 64'd0);
      check("midrst result", 64'(result), 64'd0);
      check("midrst zero", 64'(zero), 64'd0);
      check("midrst in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("midrst no output", 64'(cnt), 64'd0);

      // Randomized ops against the reference model
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) c = {2'b11, 3'($urandom_range(0, 7))};
         else c = codes[$urandom_range(0, 17)];
         a = pick_operand();
         b = pick_operand();
         run_op($sformatf("rnd%0d op%0h", i, c), c, a, b, ref32(c, a, b), ref_lat32(c, a, b));
      end

      // XLEN=16 build
      run16("x16 sra", ALU_SRA, 16'h8000, 16'd4, 16'hF800, 1);
      run16("x16 mulhu", ALU_MULHU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 17);
      run16("x16 div", ALU_DIV, 16'hFFEC, 16'd3, 16'hFFFA, 17);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
Parametrised, registered successor to the single-cycle RV32I ALU. It executes the ten base ALU ops in one cycle and the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) iteratively, one bit per cycle. It sits in the EX stage behind a valid/ready handshake, so the pipeline stalls on in_ready and drains on out_valid. A flush input kills any in-flight operation on branch mispredict or trap.

Parameters:
XLEN, 32, operand/result width; legal values 16, 32, 64.
SHW, $clog2(XLEN), shift-amount width (derived, not overridden).
CNT_W, $clog2(XLEN)+1, iteration counter width (derived).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of in-flight or pending-output op
in_valid  input  1  op request
in_ready  output  1  unit can accept op this cycle
alu_ctrl  input  5  op select (encoding below)
operand_a  input  XLEN  rs1 value
operand_b  input  XLEN  rs2/imm value
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  registered result
zero  output  1  registered (result == 0)

Behaviour:
- Encoding: bit4=0 base ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA. bit4=1: 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU. All other codes are illegal and produce result 0, zero 1.
- Shifts use operand_b[SHW-1:0]. SLT and SLTU produce a zero-extended 0/1 result. ADD and SUB wrap modulo 2^XLEN.
- Reset (async assert, sync deassert handled upstream): state IDLE, out_valid 0, result 0, zero 0, counter 0, all datapath regs 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. An accept (in_valid && in_ready) of a base op, an illegal op, or a short-circuit M op goes to DONE next cycle with the result registered, so latency is 1. Any other M op goes to BUSY, counter=XLEN.
  - BUSY: in_ready=0. One iteration per cycle, counter decrements. At counter==1, the final result (sign fix applied) is registered and the FSM goes to DONE. Accept at cycle N gives out_valid at cycle N+XLEN+1.
  - DONE: out_valid=1. result and zero are held stable while out_ready=0. On out_ready=1, in_ready=1 in the same cycle: a simultaneous accept starts the next op (back-to-back, no bubble); otherwise the FSM returns to IDLE.
- Multiply: radix-2 shift-add on magnitudes into a 2*XLEN product, negated at the end if the signs differ.
  - MUL returns low XLEN bits.
  - MULH treats a and b as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned. All three return the high XLEN bits.
- Divide: restoring divider on magnitudes. Quotient sign = sign_a ^ sign_b; remainder sign = sign_a.
- Short-circuit, 1-cycle:
  - divisor==0: DIV/DIVU give all-ones; REM/REMU give operand_a.
  - Signed overflow (a == most-negative, b == -1): DIV gives most-negative; REM gives 0.
- flush: highest priority over accept and completion. Next state IDLE, out_valid 0; result/zero keep their old value. in_valid is ignored in a flush cycle.
- rst_n low mid-op: immediate return to the reset state with no partial output.

Decomposition:
- Shared package alu_pkg:
  - alu_ctrl_e enum with the 5-bit codes above, plus constants ALU_CTRL_W=5.
  - The fsm state enum.
  - Helper function is_mdu_op(ctrl).
  - The base op 4-bit codes stay numerically identical to the existing ALU.
- One sub-module, alu_base_comb: the purely combinational ten-op XLEN ALU, reused by the top. The iterative MDU datapath and the FSM live in the top.

Test Plan:
- ADD: a=15, b=10, accepted at cycle N -> out_valid at N+1, result=25, zero=0. Then SUB 5-5 back-to-back with out_ready=1 -> result 0, zero=1, no bubble cycle.
- Multiply: MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0x00000001 at N+33; MULH on the same operands -> 0x00000000; MULHU -> 0xFFFFFFFE; MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- Divide: DIV 20/-3 -> 0xFFFFFFFA; REM 20/-3 -> 2; DIVU 0xFFFFFFFF/16 -> 0x0FFFFFFF, all at latency 33.
- Corner cases at latency 1:
  - DIV 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0, zero=1.
  - Illegal ctrl 5'b11111 -> 0.
- Backpressure and flush:
  - out_ready=0 for 5 cycles after DIV -> result stable, in_ready=0 throughout.
  - flush at BUSY cycle 10 -> out_valid never rises; next ADD completes normally.
  - rst_n pulsed low mid-MUL -> all outputs return to reset values.
- XLEN=16 rebuild: SRA 0x8000>>>4 -> 0xF800; MULHU 0xFFFF*0xFFFF -> 0xFFFE at latency 17.
